pulse_meter: RTL
================

# pulse_meter

Measures how long an input signal stays high and reports the result in whole milliseconds, counting from the global `FREQUENCY` define. It is the measuring counterpart to the game's millisecond delay timer: the timer turns a millisecond value into a wait, and this block turns an observed high pulse into a millisecond value. Typical uses are button-hold length and reaction-time capture. Results leave through a valid/ready handshake, so a slow consumer can hold the result.

## Interface
Parameters:
- WIDTH, 8, width of the millisecond result; it saturates at 2^WIDTH-1.

Ports:
- clk  input  1  system clock at `FREQUENCY` Hz.
- rst  input  1  reset: synchronous, active-high.
- arm  input  1  single-cycle request to arm a measurement; honoured only in IDLE.
- sig  input  1  signal under measurement; may be asynchronous when `PULSE_METER_SYNC_EN` is defined.
- busy  output  1  high in ARMED and MEASURE.
- ms  output  WIDTH  measured high time in ms; valid while `valid` is high.
- overflow  output  1  measured time exceeded 2^WIDTH-1 ms; valid while `valid` is high.
- valid  output  1  result available.
- ready  input  1  consumer accepts the result.

## Operation
- Tick constant: T = `FREQUENCY`/1000. The sub-ms counter is $clog2(T) bits wide and holds T-1..0.
- sig_s: the internal view of sig, either synchronised or used directly (see Configuration).
- sig_p: a register holding the previous sig_s; it samples every cycle and resets to 0.
- Rising edge: sig_s & ~sig_p. Falling edge: ~sig_s & sig_p.
- Machine states:
  - IDLE: busy=0, valid=0. arm=1 moves to ARMED.
  - ARMED: busy=1. A rising edge moves to MEASURE and clears the ms counter, overflow flag and sub-ms counter.
  - MEASURE: busy=1. Every cycle with sig_s=1 advances the sub-ms counter. Every T such cycles, ms increments.
    - If ms is already 2^WIDTH-1 when that increment would happen, ms holds and overflow is set. Overflow is sticky until the next MEASURE entry.
    - A falling edge moves to DONE.
  - DONE: valid=1, busy=0. ms and overflow stay stable until the handshake completes. valid&ready moves to IDLE on the next cycle.
- Result, with H = number of cycles sig_s was high:
  - ms = min(floor(H/T), 2^WIDTH-1).
  - overflow = (H ≥ 2^WIDTH·T).
- Partial ms are truncated and never rounded.
- arm is ignored in ARMED, MEASURE and DONE. It is not queued.
- A sig already high at arm time does not start a measurement. sig must fall and rise again.
- Glitches of one cycle while in MEASURE end the measurement; there is no filtering.
- rst in any state:
  - state returns to IDLE;
  - ms=0, overflow=0, valid=0, busy=0;
  - sig_p and the synchroniser clear;
  - any measurement in progress is discarded.

## Timing
- Reset values: busy=0, valid=0, ms=0, overflow=0.
- Synchroniser latency: L=2 cycles with `PULSE_METER_SYNC_EN` defined, L=0 without it.
- busy rises on the cycle after arm is sampled in IDLE.
- The ARMED→MEASURE transition happens at the clock edge where the rising edge is detected, L cycles after sig rises.
- valid rises L+1 cycles after the sig falling edge is sampled. The result has no further pipeline delay.
- The handshake completes on any cycle where valid&ready=1. valid is low on the following cycle.
- ready is not examined outside DONE. valid never depends combinationally on ready.
- The earliest re-arm is the cycle after valid drops. arm asserted in the handshake cycle itself is ignored.

## Configuration
- `PULSE_METER_SYNC_EN` defined:
  - sig passes through a two-flop synchroniser before edge detection, so L=2.
  - sig may come directly from a pin.
- `PULSE_METER_SYNC_EN` undefined:
  - sig_s = sig and L=0.
  - sig must already be synchronous to clk.
  - The measured H is identical for the same pulse; only the latency changes.

## Test plan
Bench settings: `FREQUENCY`=10000 (T=10), WIDTH=8, `PULSE_METER_SYNC_EN` defined unless noted.
- rst, then arm, then sig high for 35 cycles -> ms=3, overflow=0, valid=1 exactly 3 cycles after the fall, busy=0.
- arm, then sig high for 9 cycles -> ms=0, overflow=0, valid=1.
- arm, then sig high for 2600 cycles -> ms=255, overflow=1.
- Result pending with ready=0 for 20 cycles -> valid and ms stay constant. Raise ready -> valid=0 on the next cycle, state IDLE, and a new arm is accepted.
- sig held high, then arm -> busy=1 with no result. sig falls, then is high for 20 cycles -> ms=2.
- rst during MEASURE -> all outputs 0 on the next cycle. A later pulse without arm produces no valid. Repeat this case with `PULSE_METER_SYNC_EN` undefined and check that valid arrives 1 cycle after the fall.

Source files
------------

// File: rtl/pulse_meter.sv
// pulse_meter: measures how long sig stays high, in whole milliseconds.
// Tick length is FREQUENCY/1000 clock cycles.
// Optional two-flop input synchroniser: define PULSE_METER_SYNC_EN.
// Without it, sig is used directly and must already be synchronous to clk.

`ifndef FREQUENCY
`define FREQUENCY 10000
`endif

module pulse_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             sig,
  output logic             busy,
  output logic [WIDTH-1:0] ms,
  output logic             overflow,
  output logic             valid,
  input  logic             ready
);

  localparam int T  = `FREQUENCY / 1000;
  localparam int SW = (T > 1) ? $clog2(T) : 1;
  localparam logic [SW-1:0]    T_M1   = SW'(T - 1);
  localparam logic [WIDTH-1:0] MS_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;

  state_t           state_q, state_d;
  logic             sig_s, sig_p_q;
  logic             rise, fall;
  logic [SW-1:0]    sub_q, sub_d, base_sub;
  logic [WIDTH-1:0] ms_q, ms_d, base_ms;
  logic             ov_q, ov_d, base_ov;
  logic             advance;

`ifdef PULSE_METER_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser for a sig that may come straight from a pin
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], sig};
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig;
`endif

  // Previous sample of sig_s for edge detection
  always_ff @(posedge clk) begin
    if (rst) sig_p_q <= 1'b0;
    else     sig_p_q <= sig_s;
  end

  assign rise = sig_s & ~sig_p_q;
  assign fall = ~sig_s & sig_p_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm)   state_d = ARMED;
      ARMED:   if (rise)  state_d = MEASURE;
      MEASURE: if (fall)  state_d = DONE;
      DONE:    if (ready) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy  = (state_q == ARMED) || (state_q == MEASURE);
    valid = (state_q == DONE);
  end

  // Sub-ms down-counter and ms accumulator. The rising-edge cycle is itself a
  // high cycle, so MEASURE entry counts it on top of the cleared state.
  always_comb begin
    base_sub = (state_q == ARMED) ? T_M1 : sub_q;
    base_ms  = (state_q == ARMED) ? '0   : ms_q;
    base_ov  = (state_q == ARMED) ? 1'b0 : ov_q;
    advance  = ((state_q == ARMED) && rise) || ((state_q == MEASURE) && sig_s);
    sub_d    = sub_q;
    ms_d     = ms_q;
    ov_d     = ov_q;
    if (advance) begin
      ov_d = base_ov;
      if (base_sub == '0) begin
        sub_d = T_M1;
        if (base_ms == MS_MAX) begin
          ms_d = base_ms;
          ov_d = 1'b1;
        end else begin
          ms_d = base_ms + WIDTH'(1);
        end
      end else begin
        sub_d = base_sub - SW'(1);
        ms_d  = base_ms;
      end
    end
  end

  // Measurement registers; held outside ARMED/MEASURE so the result is stable
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= T_M1;
      ms_q  <= '0;
      ov_q  <= 1'b0;
    end else begin
      sub_q <= sub_d;
      ms_q  <= ms_d;
      ov_q  <= ov_d;
    end
  end

  assign ms       = ms_q;
  assign overflow = ov_q;

endmodule
